// File: rtl/sc_add_sequencer.sv
// sc_add_sequencer
// Sequencing controller for the stochastic adder datapath. It latches two
// 8-bit unipolar operands and turns them into bitstreams by comparing them
// against a shared operand LFSR. A second, independent LFSR drives the select
// input of a MUX-based scaled adder. The controller counts the ones in the
// adder output over one full 255-cycle LFSR period and returns the scaled sum
// (a+b)/2. A busy/done handshake reports progress.
//
// Parameters:
//   SEED_X   reset/start seed of the operand LFSR (must be nonzero)
//   SEED_S   reset/start seed of the select LFSR (must be nonzero)
//
// Ports:
//   clk      system clock; all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   ena      global enable; when low, all state is frozen
//   start    request a new computation; sampled only in IDLE with ena=1
//   op_a     operand A, probability op_a/255
//   op_b     operand B, probability op_b/255
//   busy     high while a computation is in progress
//   done     one-cycle pulse when result updates
//   result   count of ones in the adder output stream; holds until next done
//   y_bit    current adder output stream bit (0 outside RUN)
//   sel_bit  current select stream bit (0 outside RUN)

module sc_add_sequencer #(
   parameter logic [7:0] SEED_X = 8'h01,
   parameter logic [7:0] SEED_S = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       y_bit,
   output logic       sel_bit
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state, state_nxt;
   logic [7:0] op_a_q, op_a_nxt;
   logic [7:0] op_b_q, op_b_nxt;
   logic [7:0] lfsr_x, lfsr_x_nxt;
   logic [7:0] lfsr_s, lfsr_s_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] acc, acc_nxt;
   logic [7:0] result_nxt;
   logic       done_nxt;

   logic       run;
   logic       a_bit;
   logic       b_bit;
   logic       sel;
   logic       y;
   logic [7:0] acc_sum;

   // One step of the 8-bit maximal-length Fibonacci LFSR. Taps 7,5,4,3
   // give period 255 over the nonzero values, so every value 1..255 appears
   // exactly once per period and the comparisons below encode exactly.
   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   // Stream generation and the scaled adder. Both operand streams share
   // LFSR_X, which keeps them correlated; that is harmless because the MUX
   // picks only one of them per cycle. The select stream compares against
   // 127, giving exactly 127 ones per period (select probability ~1/2).
   // The outputs are gated to zero outside RUN so the pins stay quiet.
   always_comb begin
      run     = (state == RUN);
      a_bit   = (lfsr_x <= op_a_q);
      b_bit   = (lfsr_x <= op_b_q);
      sel     = (lfsr_s <= 8'd127);
      y       = sel ? a_bit : b_bit;
      acc_sum = acc + {7'b0, y};
      busy    = run;
      y_bit   = run & y;
      sel_bit = run & sel;
   end

   // Next-state and next-datapath logic. Everything holds by default and
   // done falls back to zero, so it is a single-cycle pulse whenever the
   // registers are enabled. Starting a run always reloads both seeds, which
   // makes every run bit-exact repeatable regardless of history.
   always_comb begin
      state_nxt  = state;
      op_a_nxt   = op_a_q;
      op_b_nxt   = op_b_q;
      lfsr_x_nxt = lfsr_x;
      lfsr_s_nxt = lfsr_s;
      cnt_nxt    = cnt;
      acc_nxt    = acc;
      result_nxt = result;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               op_a_nxt   = op_a;
               op_b_nxt   = op_b;
               lfsr_x_nxt = SEED_X;
               lfsr_s_nxt = SEED_S;
               cnt_nxt    = 8'd0;
               acc_nxt    = 8'd0;
               state_nxt  = RUN;
            end
         end
         RUN: begin
            acc_nxt    = acc_sum;
            lfsr_x_nxt = lfsr_step(lfsr_x);
            lfsr_s_nxt = lfsr_step(lfsr_s);
            // cnt counts completed RUN cycles; 254 means this is the 255th,
            // so the result must include this cycle's y via acc_sum.
            if (cnt == 8'd254) begin
               cnt_nxt    = 8'd0;
               result_nxt = acc_sum;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register. With ena low the FSM is frozen in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Datapath registers. Reset aborts any run and also clears the previous
   // result. With ena low nothing moves, including a done pulse that is
   // already high; it simply stays high until the next enabled edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q <= 8'd0;
         op_b_q <= 8'd0;
         lfsr_x <= SEED_X;
         lfsr_s <= SEED_S;
         cnt    <= 8'd0;
         acc    <= 8'd0;
         result <= 8'd0;
         done   <= 1'b0;
      end else if (ena) begin
         op_a_q <= op_a_nxt;
         op_b_q <= op_b_nxt;
         lfsr_x <= lfsr_x_nxt;
         lfsr_s <= lfsr_s_nxt;
         cnt    <= cnt_nxt;
         acc    <= acc_nxt;
         result <= result_nxt;
         done   <= done_nxt;
      end
   end

endmodule

// File: tb/tb_sc_add_sequencer.sv
// tb_sc_add_sequencer
// Directed self-checking bench for sc_add_sequencer. Expected results are
// pushed to a scoreboard queue when a start is driven and popped when the
// DUT raises done. A small behavioural model of the two LFSRs checks the
// y_bit/sel_bit streams cycle by cycle and produces the expected result
// for operand pairs whose sum is not a closed-form constant.

module tb_sc_add_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       start = 1'b0;
   logic [7:0] op_a = 8'd0;
   logic [7:0] op_b = 8'd0;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       y_bit;
   logic       sel_bit;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mx;
   logic [7:0] ms;
   logic [7:0] first_result;
   logic [7:0] r;
   logic [7:0] m;

   sc_add_sequencer #(
      .SEED_X(8'h01),
      .SEED_S(8'hA5)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .y_bit  (y_bit),
      .sel_bit(sel_bit)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Reference LFSR step, written from the polynomial x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] model_step(input logic [7:0] q);
      logic fb;
      fb = q[7] ^ q[5] ^ q[4] ^ q[3];
      return {q[6:0], fb};
   endfunction

   // Reference result: ones in the MUX output over one full period
   function automatic logic [7:0] model_result(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x;
      logic [7:0] s;
      logic [7:0] cnt1;
      x    = 8'h01;
      s    = 8'hA5;
      cnt1 = 8'd0;
      for (int i = 0; i < 255; i++) begin
         if ((s <= 8'd127) ? (x <= a) : (x <= b)) cnt1 = cnt1 + 8'd1;
         x = model_step(x);
         s = model_step(s);
      end
      return cnt1;
   endfunction

   // One comparison: counts it, and on mismatch counts a failure and reports
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive a start with the given operands (called #1 after an edge, in IDLE)
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] expected);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      exp_q.push_back(expected);
      @(posedge clk);
      #1;
      start = 1'b0;
      mx    = 8'h01;
      ms    = 8'hA5;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Full run: start, follow streams against the model, wait for done with a
   // cycle budget, then check latency, handshake and scoreboard result.
   task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expected, input int gap,
                        input bit hold_start, input bit freeze_done,
                        output logic [7:0] got);
      int         cycles;
      bit         seen;
      bit         early;
      logic       exp_y;
      logic [7:0] e;
      applyStimulus(a, b, expected);
      cycles = 0;
      seen   = 1'b0;
      early  = 1'b0;
      while (!seen && cycles < 400) begin
         if (busy) begin
            exp_y = (ms <= 8'd127) ? (mx <= a) : (mx <= b);
            checkOutput("sel_bit", 32'(sel_bit), 32'(ms <= 8'd127));
            checkOutput("y_bit", 32'(y_bit), 32'(exp_y));
         end
         ena = !(gap > 0 && cycles >= 50 && cycles < 50 + gap);
         if (hold_start) begin
            start = (cycles >= 5 && cycles < 200);
            op_a  = ~a;
            op_b  = ~b;
         end
         @(posedge clk);
         #1;
         cycles++;
         if (ena) begin
            mx = model_step(mx);
            ms = model_step(ms);
         end
         if (done) seen = 1'b1;
         else if (!busy) early = 1'b1;
      end
      ena   = 1'b1;
      start = 1'b0;
      op_a  = a;
      op_b  = b;
      checkOutput("done_seen", 32'(seen), 32'd1);
      checkOutput("latency", 32'(cycles), 32'(255 + gap));
      checkOutput("busy_early_drop", 32'(early), 32'd0);
      checkOutput("busy_at_done", 32'(busy), 32'd0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("result", 32'(result), 32'(e));
      end else begin
         checkOutput("scoreboard_size", 32'(exp_q.size()), 32'd1);
      end
      got = result;
      if (freeze_done) begin
         ena = 1'b0;
         @(posedge clk);
         #1;
         checkOutput("done_held_ena_low", 32'(done), 32'd1);
         ena = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput("done_cleared", 32'(done), 32'd0);
      checkOutput("result_hold", 32'(result), 32'(got));
   endtask

   // Directed sequence
   initial begin
      rst_n = 1'b0;
      ena   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_y_bit", 32'(y_bit), 32'd0);
      checkOutput("reset_sel_bit", 32'(sel_bit), 32'd0);
      rst_n = 1'b1;
      ena   = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] zero operands");
      runOp(8'd0, 8'd0, 8'd0, 0, 1'b0, 1'b0, r);
      $display("[TB] select-only streams");
      runOp(8'd255, 8'd0, 8'd127, 0, 1'b0, 1'b0, r);
      runOp(8'd0, 8'd255, 8'd128, 0, 1'b0, 1'b0, r);
      $display("[TB] equal operands, done frozen by ena");
      runOp(8'd100, 8'd100, 8'd100, 0, 1'b0, 1'b1, r);
      runOp(8'd255, 8'd255, 8'd255, 0, 1'b0, 1'b0, r);

      $display("[TB] repeatability, start held in RUN, ena gap");
      m = model_result(8'd200, 8'd50);
      runOp(8'd200, 8'd50, m, 0, 1'b0, 1'b0, first_result);
      runOp(8'd200, 8'd50, m, 0, 1'b1, 1'b0, r);
      checkOutput("repeat_identical", 32'(r), 32'(first_result));
      runOp(8'd200, 8'd50, m, 10, 1'b0, 1'b0, r);
      checkOutput("ena_gap_same_result", 32'(r), 32'(first_result));

      $display("[TB] reset mid-run");
      applyStimulus(8'd200, 8'd50, m);
      repeat (99) @(posedge clk);
      #1;
      checkOutput("busy_before_reset", 32'(busy), 32'd1);
      checkOutput("result_before_reset", 32'(result), 32'(first_result));
      rst_n = 1'b0;
      #2;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      checkOutput("abort_y_bit", 32'(y_bit), 32'd0);
      checkOutput("abort_sel_bit", 32'(sel_bit), 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle_after_reset", 32'(busy), 32'd0);
      runOp(8'd255, 8'd0, 8'd127, 0, 1'b0, 1'b0, r);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
